// File: rtl/wb_select_stage.sv
// wb_select_stage: NSRC-way writeback selector with load extraction/extension,
// registered output with stall, sticky error flags and a retire counter.
module wb_select_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 4,
  parameter int unsigned SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NSRC*WIDTH-1:0] inSrc,
  input  logic [SEL_W-1:0]      mSel,
  input  logic                  inValid,
  input  logic                  inRegWrite,
  input  logic [4:0]            inRegDst,
  input  logic [1:0]            inLoadSize,
  input  logic                  inLoadSigned,
  input  logic [1:0]            inAddrLow,
  input  logic                  stall,
  output logic [WIDTH-1:0]      mWrite,
  output logic [4:0]            outRegDst,
  output logic                  outRegWrite,
  output logic                  outValid,
  output logic                  errSel,
  output logic                  errAlign,
  output logic [31:0]           retireCount
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 32;

  logic              selInRange;
  logic              isLoad;
  logic [WIDTH-1:0]  selData;
  logic [WORD_W-1:0] loadWord;
  logic [HALF_W-1:0] loadHalf;
  logic [BYTE_W-1:0] loadByte;
  logic [WORD_W-1:0] loadRaw;
  logic [WIDTH-1:0]  keepMask;
  logic              signBit;
  logic              misalign;
  logic [WIDTH-1:0]  loadExt;
  logic [WIDTH-1:0]  dataNext;
  logic              selErrNext;
  logic              alignErrNext;
  logic              regWriteNext;

  // Plain source selection; out-of-range selects leave selData at zero.
  always_comb begin
    selInRange = 1'b0;
    selData    = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (32'(mSel) == k) begin
        selInRange = 1'b1;
        selData    = inSrc[k*WIDTH +: WIDTH];
      end
    end
  end

  // Load lane extraction, alignment check and sign/zero extension from source 1.
  always_comb begin
    loadWord = inSrc[WIDTH +: WORD_W];
    loadHalf = inAddrLow[1] ? loadWord[31:16] : loadWord[15:0];
    case (inAddrLow)
      2'd0:    loadByte = loadWord[7:0];
      2'd1:    loadByte = loadWord[15:8];
      2'd2:    loadByte = loadWord[23:16];
      default: loadByte = loadWord[31:24];
    endcase
    loadRaw  = loadWord;
    signBit  = loadWord[WORD_W-1];
    keepMask = WIDTH'({WORD_W{1'b1}});
    misalign = |inAddrLow;
    case (inLoadSize)
      2'b01: begin
        loadRaw  = WORD_W'(loadHalf);
        signBit  = loadHalf[HALF_W-1];
        keepMask = WIDTH'({HALF_W{1'b1}});
        misalign = inAddrLow[0];
      end
      2'b10: begin
        loadRaw  = WORD_W'(loadByte);
        signBit  = loadByte[BYTE_W-1];
        keepMask = WIDTH'({BYTE_W{1'b1}});
        misalign = 1'b0;
      end
      default: ;
    endcase
    loadExt = WIDTH'(loadRaw);
    if (inLoadSigned && signBit) begin
      loadExt = loadExt | ~keepMask;
    end
  end

  // Final data mux, error detection and qualified write enable.
  always_comb begin
    isLoad = (mSel == SEL_W'(1));
    if (!selInRange) begin
      dataNext = '0;
    end else if (isLoad) begin
      dataNext = loadExt;
    end else begin
      dataNext = selData;
    end
    selErrNext   = inValid & ~selInRange;
    alignErrNext = inValid & isLoad & misalign;
    regWriteNext = inValid & inRegWrite & (|inRegDst) & selInRange & ~(isLoad & misalign);
  end

  // Output pipeline register with stall hold; sticky flags and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mWrite      <= '0;
      outRegDst   <= '0;
      outRegWrite <= 1'b0;
      outValid    <= 1'b0;
      errSel      <= 1'b0;
      errAlign    <= 1'b0;
      retireCount <= '0;
    end else if (!stall) begin
      mWrite      <= dataNext;
      outRegDst   <= inRegDst;
      outRegWrite <= regWriteNext;
      outValid    <= inValid;
      errSel      <= errSel | selErrNext;
      errAlign    <= errAlign | alignErrNext;
      if (regWriteNext) begin
        retireCount <= retireCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_select_stage.sv
// Scoreboard bench for wb_select_stage: NSRC=4 main instance, NSRC=3 instance for illegal selects.
module tb_wb_select_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] src4;
  logic [95:0]  src3;
  logic [1:0]   mSel;
  logic         inValid, inRegWrite, inLoadSigned, stall;
  logic [4:0]   inRegDst;
  logic [1:0]   inLoadSize, inAddrLow;

  logic [31:0]  mWrite4, mWrite3, cnt4, cnt3;
  logic [4:0]   dst4, dst3;
  logic         wr4, wr3, valid4, valid3, eSel4, eSel3, eAlign4, eAlign3;

  typedef struct {
    logic [31:0] data;
    logic        wr;
    logic [4:0]  dst;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sbQ[$];
  exp_t        e;
  logic [31:0] expCount;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  wb_select_stage #(.WIDTH(32), .NSRC(4)) dut4 (
    .clk(clk), .rst(rst), .inSrc(src4), .mSel(mSel), .inValid(inValid),
    .inRegWrite(inRegWrite), .inRegDst(inRegDst), .inLoadSize(inLoadSize),
    .inLoadSigned(inLoadSigned), .inAddrLow(inAddrLow), .stall(stall),
    .mWrite(mWrite4), .outRegDst(dst4), .outRegWrite(wr4), .outValid(valid4),
    .errSel(eSel4), .errAlign(eAlign4), .retireCount(cnt4)
  );

  wb_select_stage #(.WIDTH(32), .NSRC(3)) dut3 (
    .clk(clk), .rst(rst), .inSrc(src3), .mSel(mSel), .inValid(inValid),
    .inRegWrite(inRegWrite), .inRegDst(inRegDst), .inLoadSize(inLoadSize),
    .inLoadSigned(inLoadSigned), .inAddrLow(inAddrLow), .stall(stall),
    .mWrite(mWrite3), .outRegDst(dst3), .outRegWrite(wr3), .outValid(valid3),
    .errSel(eSel3), .errAlign(eAlign3), .retireCount(cnt3)
  );

  // One non-stalled capture; expected result for dut4 goes on the scoreboard.
  task automatic drive(input logic [1:0] sel, input logic [1:0] size, input logic sgn,
                       input logic [1:0] addr, input logic valid, input logic rw,
                       input logic [4:0] dst, input logic [31:0] expData, input logic expWr);
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;
    mSel = sel; inLoadSize = size; inLoadSigned = sgn; inAddrLow = addr;
    inValid = valid; inRegWrite = rw; inRegDst = dst;
    if (expWr) expCount = expCount + 32'd1;
    sbQ.push_back('{expData, expWr, dst, valid, expCount});
    @(posedge clk); #1;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; stall = 1'b0;
    expCount = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b1; src4 = {4{$urandom}}; src3 = {3{$urandom}};
    mSel = 2'd3; inValid = 1'b1; inRegWrite = 1'b1; inRegDst = 5'd9;
    inLoadSize = 2'b00; inLoadSigned = 1'b1; inAddrLow = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mWrite4 !== 32'd0) begin errors++; $display("FAIL reset_mWrite got %h want 0", mWrite4); end
    checks++; if (dst4 !== 5'd0) begin errors++; $display("FAIL reset_dst got %0d want 0", dst4); end
    checks++; if (wr4 !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", wr4); end
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid4); end
    checks++; if (eSel4 !== 1'b0 || eSel3 !== 1'b0) begin errors++; $display("FAIL reset_errSel got %b/%b want 0", eSel4, eSel3); end
    checks++; if (eAlign4 !== 1'b0) begin errors++; $display("FAIL reset_errAlign got %b want 0", eAlign4); end
    checks++; if (cnt4 !== 32'd0) begin errors++; $display("FAIL reset_count got %h want 0", cnt4); end
    rst = 1'b0; stall = 1'b0;
    expCount = '0;
  endtask

  task automatic test_select();
    logic [1:0]  sels[3] = '{2'd0, 2'd2, 2'd3};
    logic [31:0] want[3] = '{32'h11111111, 32'h33333333, 32'h44444444};
    src4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    for (int i = 0; i < 3; i++) begin
      drive(sels[i], 2'b00, 1'b1, 2'd3, 1'b1, 1'b1, 5'd5, want[i], 1'b1);
      if (sbQ.size() == 0) begin
        checks++; errors++; $display("FAIL select%0d scoreboard empty", i);
      end else begin
        e = sbQ.pop_front();
        checks++;
        if (mWrite4 !== e.data || wr4 !== e.wr || dst4 !== e.dst || valid4 !== e.valid || cnt4 !== e.cnt) begin
          errors++;
          $display("FAIL select%0d got d=%h w=%b r=%0d v=%b c=%0d want d=%h w=%b r=%0d v=%b c=%0d",
                   i, mWrite4, wr4, dst4, valid4, cnt4, e.data, e.wr, e.dst, e.valid, e.cnt);
        end
      end
    end
    checks++; if (cnt4 !== 32'd3) begin errors++; $display("FAIL select_count got %0d want 3", cnt4); end
  endtask

  task automatic test_load();
    logic [1:0]  sizes[7] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
    logic        sgns[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  addrs[7] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    logic [31:0] want[7]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8081, 32'h0000F0F7,
                              32'hFFFFFFF0, 32'h00000081, 32'h8081F0F7};
    src4 = {32'h44444444, 32'h33333333, 32'h8081F0F7, 32'h11111111};
    for (int i = 0; i < 7; i++) begin
      drive(2'd1, sizes[i], sgns[i], addrs[i], 1'b1, 1'b1, 5'd7, want[i], 1'b1);
      if (sbQ.size() == 0) begin
        checks++; errors++; $display("FAIL load%0d scoreboard empty", i);
      end else begin
        e = sbQ.pop_front();
        checks++;
        if (mWrite4 !== e.data || wr4 !== e.wr || cnt4 !== e.cnt) begin
          errors++;
          $display("FAIL load%0d got d=%h w=%b c=%0d want d=%h w=%b c=%0d",
                   i, mWrite4, wr4, cnt4, e.data, e.wr, e.cnt);
        end
      end
    end
    checks++; if (eAlign4 !== 1'b0) begin errors++; $display("FAIL load_errAlign got %b want 0", eAlign4); end
  endtask

  task automatic test_misalign();
    src4 = {32'h44444444, 32'h33333333, 32'h8081F0F7, 32'h0BADF00D};
    drive(2'd1, 2'b00, 1'b0, 2'd1, 1'b1, 1'b1, 5'd4, 32'h8081F0F7, 1'b0);
    e = sbQ.pop_front();
    checks++;
    if (mWrite4 !== e.data || wr4 !== e.wr || cnt4 !== e.cnt || eAlign4 !== 1'b1) begin
      errors++;
      $display("FAIL misalign_word got d=%h w=%b c=%0d ea=%b want d=%h w=%b c=%0d ea=1",
               mWrite4, wr4, cnt4, eAlign4, e.data, e.wr, e.cnt);
    end
    drive(2'd1, 2'b01, 1'b1, 2'd3, 1'b1, 1'b1, 5'd4, 32'hFFFF8081, 1'b0);
    e = sbQ.pop_front();
    checks++;
    if (mWrite4 !== e.data || wr4 !== e.wr || cnt4 !== e.cnt) begin
      errors++;
      $display("FAIL misalign_half got d=%h w=%b c=%0d want d=%h w=%b c=%0d",
               mWrite4, wr4, cnt4, e.data, e.wr, e.cnt);
    end
    for (int i = 0; i < 10; i++) begin
      drive(2'd0, 2'b00, 1'b0, 2'd1, 1'b1, 1'b1, 5'd6, 32'h0BADF00D, 1'b1);
      e = sbQ.pop_front();
      checks++;
      if (eAlign4 !== 1'b1 || eSel4 !== 1'b0 || mWrite4 !== e.data || cnt4 !== e.cnt) begin
        errors++;
        $display("FAIL misalign_sticky%0d got ea=%b es=%b d=%h c=%0d want ea=1 es=0 d=%h c=%0d",
                 i, eAlign4, eSel4, mWrite4, cnt4, e.data, e.cnt);
      end
    end
    applyReset();
    checks++; if (eAlign4 !== 1'b0 || cnt4 !== 32'd0) begin errors++; $display("FAIL misalign_clear got ea=%b c=%0d want ea=0 c=0", eAlign4, cnt4); end
  endtask

  task automatic test_illegal_and_r0();
    src3 = {32'h33333333, 32'h22222222, 32'h11111111};
    src4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    drive(2'd3, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 5'd8, 32'h44444444, 1'b0);
    e = sbQ.pop_front();
    checks++; if (eSel3 !== 1'b0 || valid4 !== 1'b0 || wr4 !== 1'b0) begin errors++; $display("FAIL invalid_slot got es3=%b v=%b w=%b want 0 0 0", eSel3, valid4, wr4); end
    drive(2'd3, 2'b00, 1'b0, 2'd0, 1'b1, 1'b1, 5'd8, 32'h44444444, 1'b1);
    e = sbQ.pop_front();
    checks++;
    if (mWrite3 !== 32'd0 || wr3 !== 1'b0 || eSel3 !== 1'b1 || cnt3 !== 32'd0) begin
      errors++;
      $display("FAIL illegal_sel got d=%h w=%b es=%b c=%0d want d=0 w=0 es=1 c=0", mWrite3, wr3, eSel3, cnt3);
    end
    checks++; if (mWrite4 !== e.data || wr4 !== e.wr || eSel4 !== 1'b0) begin errors++; $display("FAIL legal_sel3 got d=%h w=%b es=%b want d=%h w=%b es=0", mWrite4, wr4, eSel4, e.data, e.wr); end
    drive(2'd2, 2'b00, 1'b0, 2'd0, 1'b1, 1'b1, 5'd0, 32'h33333333, 1'b0);
    e = sbQ.pop_front();
    checks++;
    if (mWrite4 !== e.data || wr4 !== e.wr || cnt4 !== e.cnt || eSel3 !== 1'b1) begin
      errors++;
      $display("FAIL r0_write got d=%h w=%b c=%0d es3=%b want d=%h w=%b c=%0d es3=1",
               mWrite4, wr4, cnt4, eSel3, e.data, e.wr, e.cnt);
    end
  endtask

  task automatic test_stall();
    logic [31:0] holdCnt;
    src4[31:0] = 32'hAAAA0000;
    drive(2'd0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b1, 5'd3, 32'hAAAA0000, 1'b1);
    e = sbQ.pop_front();
    checks++; if (mWrite4 !== e.data || cnt4 !== e.cnt) begin errors++; $display("FAIL stall_pre got d=%h c=%0d want d=%h c=%0d", mWrite4, cnt4, e.data, e.cnt); end
    holdCnt = e.cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1'b1; src4[31:0] = 32'h55550000; inRegDst = 5'd12; inValid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (mWrite4 !== 32'hAAAA0000 || cnt4 !== holdCnt || dst4 !== 5'd3 || valid4 !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d got d=%h c=%0d r=%0d v=%b want d=aaaa0000 c=%0d r=3 v=1",
                 i, mWrite4, cnt4, dst4, valid4, holdCnt);
      end
    end
    drive(2'd0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b1, 5'd3, 32'h55550000, 1'b1);
    e = sbQ.pop_front();
    checks++; if (mWrite4 !== e.data || cnt4 !== e.cnt) begin errors++; $display("FAIL stall_release got d=%h c=%0d want d=%h c=%0d", mWrite4, cnt4, e.data, e.cnt); end
  endtask

  task automatic test_wrap();
    force dut4.retireCount = 32'hFFFFFFFF;
    #1;
    release dut4.retireCount;
    expCount = 32'hFFFFFFFF;
    drive(2'd0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b1, 5'd2, 32'h55550000, 1'b1);
    e = sbQ.pop_front();
    checks++; if (cnt4 !== e.cnt || cnt4 !== 32'd0) begin errors++; $display("FAIL count_wrap got %h want %h", cnt4, e.cnt); end
  endtask

  task automatic test_reset_in_stall();
    src4 = {32'h44444444, 32'h33333333, 32'h8081F0F7, 32'h11111111};
    drive(2'd1, 2'b00, 1'b0, 2'd2, 1'b1, 1'b1, 5'd9, 32'h8081F0F7, 1'b0);
    e = sbQ.pop_front();
    checks++; if (eAlign4 !== 1'b1) begin errors++; $display("FAIL pre_stall_reset_errAlign got %b want 1", eAlign4); end
    @(negedge clk);
    stall = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mWrite4 !== 32'd0 || eAlign4 !== 1'b0 || eSel3 !== 1'b0 || cnt4 !== 32'd0 || valid4 !== 1'b0 || dst4 !== 5'd0) begin
      errors++;
      $display("FAIL reset_in_stall got d=%h ea=%b es3=%b c=%0d v=%b r=%0d want all 0",
               mWrite4, eAlign4, eSel3, cnt4, valid4, dst4);
    end
    rst = 1'b0; stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; expCount = '0;
    src4 = '0; src3 = '0; mSel = '0; inValid = 1'b0; inRegWrite = 1'b0;
    inRegDst = '0; inLoadSize = '0; inLoadSigned = 1'b0; inAddrLow = '0;
    test_reset();
    test_select();
    test_load();
    test_misalign();
    test_illegal_and_r0();
    test_stall();
    test_wrap();
    test_reset_in_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
